// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, Status bit positions and exception FSM encoding
`timescale 1ns/1ps
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS_IDX = 5'd12;
  localparam logic [4:0] CP0_CAUSE_IDX  = 5'd13;
  localparam logic [4:0] CP0_EPC_IDX    = 5'd14;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SAVE_EPC    = 3'd1,
    SAVE_CAUSE  = 3'd2,
    SAVE_STATUS = 3'd3,
    ERET_EPC    = 3'd4,
    ERET_STATUS = 3'd5,
    REDIRECT    = 3'd6
  } cp0_state_e;

  // Status value with only the EXL/IE bits replaced; all other bits kept.
  function automatic logic [31:0] status_with(input logic [31:0] status,
                                              input logic        exl,
                                              input logic        ie);
    logic [31:0] s;
    s                 = status;
    s[STATUS_EXL_BIT] = exl;
    s[STATUS_IE_BIT]  = ie;
    return s;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception entry / ERET sequencer driving the CP0 register file
// External interrupt input and its gating exist only when CP0_EXT_INT_EN is defined.
`timescale 1ns/1ps
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_VEC = 32'h0000_0004,
  parameter logic [4:0]  EXCCODE_INT = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret_req,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
`ifdef CP0_EXT_INT_EN
  input  logic        ext_int,
`endif
  output logic        cp0_we,
  output logic [4:0]  cp0_wt_addr,
  output logic [31:0] cp0_wt_data,
  output logic [4:0]  cp0_r_addr,
  input  logic [31:0] cp0_rdata,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  cp0_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  code_q, code_d;
  logic        eret_q, eret_d;
  logic [31:0] shadow_q, shadow_d;

  logic        int_take;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  r_addr;
  logic        redir;
  logic        idle;

`ifdef CP0_EXT_INT_EN
  assign int_take = ext_int & shadow_q[STATUS_IE_BIT] & ~shadow_q[STATUS_EXL_BIT] & ~exc_req;
`else
  assign int_take = 1'b0;
`endif

  assign idle = (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    code_d   = code_q;
    eret_d   = eret_q;
    shadow_d = shadow_q;
    wr_en    = 1'b0;
    wr_addr  = mtc0_addr;
    wr_data  = mtc0_data;
    r_addr   = mfc0_addr;
    redir    = 1'b0;

    case (state_q)
      IDLE: begin
        if (exc_req) begin
          state_d = SAVE_EPC;
          pc_d    = exc_pc;
          code_d  = exc_code;
          eret_d  = 1'b0;
        end else if (int_take) begin
          state_d = SAVE_EPC;
          pc_d    = exc_pc;
          code_d  = EXCCODE_INT;
          eret_d  = 1'b0;
        end else if (eret_req) begin
          state_d = ERET_EPC;
          eret_d  = 1'b1;
        end else begin
          wr_en = mtc0_we;
        end
      end
      SAVE_EPC: begin
        wr_en   = 1'b1;
        wr_addr = CP0_EPC_IDX;
        wr_data = pc_q;
        state_d = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        wr_en   = 1'b1;
        wr_addr = CP0_CAUSE_IDX;
        wr_data = {25'b0, code_q, 2'b00};
        state_d = SAVE_STATUS;
      end
      SAVE_STATUS: begin
        wr_en   = 1'b1;
        wr_addr = CP0_STATUS_IDX;
        wr_data = status_with(shadow_q, 1'b1, 1'b0);
        state_d = REDIRECT;
      end
      ERET_EPC: begin
        // pc_q doubles as the ERET target once the exception path is done with it.
        r_addr  = CP0_EPC_IDX;
        pc_d    = cp0_rdata;
        state_d = ERET_STATUS;
      end
      ERET_STATUS: begin
        wr_en   = 1'b1;
        wr_addr = CP0_STATUS_IDX;
        wr_data = status_with(shadow_q, 1'b0, 1'b1);
        state_d = REDIRECT;
      end
      REDIRECT: begin
        redir   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en && (wr_addr == CP0_STATUS_IDX)) begin
      shadow_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      code_q   <= '0;
      eret_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      code_q   <= code_d;
      eret_q   <= eret_d;
      shadow_q <= shadow_d;
    end
  end

  // Reset blanks strobes combinationally so an aborted sequence issues no further writes.
  assign cp0_we      = wr_en & ~rst;
  assign cp0_wt_addr = wr_addr;
  assign cp0_wt_data = wr_data;
  assign cp0_r_addr  = r_addr;
  assign mfc0_data   = cp0_rdata;
  assign busy        = ~idle & ~rst;
  assign stall       = ~rst & (~idle | (exc_req | int_take | eret_req));
  assign pc_redirect = redir & ~rst;
  assign redirect_pc = eret_q ? pc_q : HANDLER_VEC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - randomized bench for cp0_exc_ctrl with behavioural CP0 register file and transaction model
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;

  localparam logic [31:0] HVEC     = 32'h0000_0004;
  localparam logic [4:0]  INT_CODE = 5'd0;
`ifdef CP0_EXT_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        exc_req, eret_req, mtc0_we;
  logic [4:0]  exc_code, mtc0_addr, mfc0_addr;
  logic [31:0] exc_pc, mtc0_data, mfc0_data;
  logic        cp0_we, stall, pc_redirect, busy;
  logic [4:0]  cp0_wt_addr, cp0_r_addr;
  logic [31:0] cp0_wt_data, cp0_rdata, redirect_pc;
`ifdef CP0_EXT_INT_EN
  logic        ext_int;
`endif

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc),
    .eret_req(eret_req),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
`ifdef CP0_EXT_INT_EN
    .ext_int(ext_int),
`endif
    .cp0_we(cp0_we), .cp0_wt_addr(cp0_wt_addr), .cp0_wt_data(cp0_wt_data),
    .cp0_r_addr(cp0_r_addr), .cp0_rdata(cp0_rdata),
    .stall(stall), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  // CP0 register file the controller drives
  logic [31:0] rf [32];
  logic        rf_clr;
  assign cp0_rdata = rf[cp0_r_addr];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (cp0_we) begin
      rf[cp0_wt_addr] <= cp0_wt_data;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad;
  logic [31:0] mrf [32];
  logic [31:0] msh;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drop_reqs();
    exc_req  = 1'b0;
    eret_req = 1'b0;
    mtc0_we  = 1'b0;
`ifdef CP0_EXT_INT_EN
    ext_int  = 1'b0;
`endif
  endtask

  // One pipeline request held until the sequence completes; called right after a falling edge.
  task automatic run_txn(input logic e, input logic [4:0] code, input logic [31:0] pc,
                         input logic r, input logic m, input logic [4:0] ma,
                         input logic [31:0] md, input logic irq, input logic [4:0] rd_a);
    logic        we_x [5];
    logic [4:0]  a_x  [5];
    logic [31:0] d_x  [5];
    int          lat;
    logic [31:0] rpc;
    logic        take_int;
    for (int i = 0; i < 5; i++) begin
      we_x[i] = 1'b0; a_x[i] = '0; d_x[i] = '0;
    end
    rpc      = '0;
    take_int = irq & msh[0] & ~msh[1] & ~e;
    if (e || take_int) begin
      lat = 4;
      we_x[1] = 1'b1; a_x[1] = 5'd14; d_x[1] = pc;
      we_x[2] = 1'b1; a_x[2] = 5'd13; d_x[2] = {25'b0, (e ? code : INT_CODE), 2'b00};
      we_x[3] = 1'b1; a_x[3] = 5'd12; d_x[3] = (msh | 32'h2) & ~32'h1;
      rpc = HVEC;
    end else if (r) begin
      lat = 3;
      we_x[2] = 1'b1; a_x[2] = 5'd12; d_x[2] = (msh & ~32'h2) | 32'h1;
      rpc = mrf[14];
    end else begin
      lat = 0;
      we_x[0] = m; a_x[0] = ma; d_x[0] = md;
    end

    exc_req = e; exc_code = code; exc_pc = pc; eret_req = r;
    mtc0_we = m; mtc0_addr = ma; mtc0_data = md; mfc0_addr = rd_a;
`ifdef CP0_EXT_INT_EN
    ext_int = irq;
`endif
    for (int c = 0; c <= lat; c++) begin
      #2;
      check("cp0_we", 32'(cp0_we), 32'(we_x[c]));
      if (we_x[c]) begin
        check("wt_addr", 32'(cp0_wt_addr), 32'(a_x[c]));
        check("wt_data", cp0_wt_data, d_x[c]);
      end
      check("stall", 32'(stall), 32'(lat > 0));
      check("busy", 32'(busy), 32'(c > 0));
      check("pc_redirect", 32'(pc_redirect), 32'(lat > 0 && c == lat));
      if (lat > 0 && c == lat) check("redirect_pc", redirect_pc, rpc);
      if (c == 0) check("mfc0_data", mfc0_data, mrf[rd_a]);
      if (we_x[c]) begin
        mrf[a_x[c]] = d_x[c];
        if (a_x[c] == 5'd12) msh = d_x[c];
      end
      @(negedge clk);
    end
    drop_reqs();
  endtask

  task automatic rst_mid_seq();
    exc_req = 1'b1; exc_code = 5'd7; exc_pc = 32'h0000_0abc; mfc0_addr = 5'd0;
    #2;
    check("rm_stall0", 32'(stall), 32'd1);
    @(negedge clk);
    #2;
    check("rm_epc_we", 32'(cp0_we), 32'd1);
    check("rm_epc_addr", 32'(cp0_wt_addr), 32'd14);
    mrf[14] = 32'h0000_0abc;
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rm_we_in_rst", 32'(cp0_we), 32'd0);
    check("rm_stall_in_rst", 32'(stall), 32'd0);
    check("rm_busy_in_rst", 32'(busy), 32'd0);
    check("rm_redir_in_rst", 32'(pc_redirect), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drop_reqs();
    msh = '0;
    #2;
    check("rm_busy_after", 32'(busy), 32'd0);
    check("rm_stall_after", 32'(stall), 32'd0);
    check("rm_we_after", 32'(cp0_we), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic e, r, m, irq;
    logic [4:0] ma;
    n_cmp = 0; n_bad = 0;
    rf_clr = 1'b1; rst = 1'b1;
    exc_req = 1'b1; exc_code = 5'd1; exc_pc = 32'h40; eret_req = 1'b1;
    mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'h3; mfc0_addr = 5'd0;
`ifdef CP0_EXT_INT_EN
    ext_int = 1'b1;
`endif
    repeat (3) @(negedge clk);
    #2;
    check("rst_cp0_we", 32'(cp0_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_redirect", 32'(pc_redirect), 32'd0);
    @(negedge clk);
    rst = 1'b0; rf_clr = 1'b0;
    drop_reqs();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    msh = '0;
    @(negedge clk);

    // exception entry
    run_txn(1'b1, 5'd12, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("exc_epc", rf[14], 32'h100);
    check("exc_cause", rf[13], 32'h30);
    check("exc_status", 32'(rf[12][1:0]), 32'h2);
    // simultaneous exc + eret + mtc0
    run_txn(1'b1, 5'd3, 32'h180, 1'b1, 1'b1, 5'd5, 32'hdead_beef, 1'b0, 5'd5);
    check("simul_no_mtc0", rf[5], 32'h0);
    // ERET
    run_txn(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd14, 32'h200, 1'b0, 5'd14);
    run_txn(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h2, 1'b0, 5'd12);
    run_txn(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd12);
    check("eret_status", rf[12], 32'h1);
    // mtc0 forwarding then mfc0
    run_txn(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h1, 1'b0, 5'd12);
    run_txn(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd12);
    check("mfc0_status", mfc0_data, 32'h1);
    rst_mid_seq();
`ifdef CP0_EXT_INT_EN
    run_txn(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0, 1'b0, 5'd0);
    run_txn(1'b0, 5'd0, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    run_txn(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h1, 1'b0, 5'd0);
    run_txn(1'b0, 5'd0, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    check("int_cause", rf[13], 32'h0);
    check("int_epc", rf[14], 32'h300);
`endif

    for (int t = 0; t < 300; t++) begin
      e   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 3) == 0);
      m   = 1'($urandom_range(0, 1));
      irq = INT_EN & ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       ma = 5'd12;
        1:       ma = 5'd13;
        2:       ma = 5'd14;
        default: ma = 5'($urandom_range(0, 31));
      endcase
      run_txn(e, 5'($urandom_range(0, 31)), $urandom, r, m, ma, $urandom, irq,
              5'($urandom_range(0, 31)));
    end

    for (int i = 0; i < 32; i++) check($sformatf("rf_final[%0d]", i), rf[i], mrf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
